pc_stack_sequencer: RTL and testbench

- Program-counter sequencer that sits directly upstream of the 16-bit hardware return stack.
- Owns the PC and advances it by increment, branch, CALL or RET.
- On CALL it pushes the return address into the stack. On RET it pops the stack's PC port and loads the value it gets back.
- Tracks stack depth itself, so it flags overflow/underflow before issuing a bad stack operation.

---
 rtl/pc_stack_sequencer_if.sv | 51 +++++
 rtl/pc_stack_sequencer.sv | 126 ++++++++++++
 tb/tb_pc_stack_sequencer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_stack_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_stack_sequencer_if
// Description : Bundles the request inputs, the return-stack bus and the
//               status outputs of pc_stack_sequencer into one interface.
//               slave  - the sequencer side (consumes requests, drives the
//                        stack bus and status).
//               master - the environment side (issues requests, models the
//                        stack's PC output, observes status).
// Ports       : run, br_take, br_target, call_req, call_target, ret_req,
//               stack_pc_data (toward sequencer); pc, stack_data, stack_en,
//               stack_pc_en, stack_valid, busy, depth, ovf_err, unf_err
//               (from sequencer).
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_stack_sequencer_if #(
  parameter int PC_W    = 16,
  parameter int DEPTH_W = 5
);
  logic               run;
  logic               br_take;
  logic [PC_W-1:0]    br_target;
  logic               call_req;
  logic [PC_W-1:0]    call_target;
  logic               ret_req;
  logic [PC_W-1:0]    stack_pc_data;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    stack_data;
  logic               stack_en;
  logic               stack_pc_en;
  logic               stack_valid;
  logic               busy;
  logic [DEPTH_W-1:0] depth;
  logic               ovf_err;
  logic               unf_err;

  modport slave (
    input  run, br_take, br_target, call_req, call_target, ret_req,
           stack_pc_data,
    output pc, stack_data, stack_en, stack_pc_en, stack_valid, busy, depth,
           ovf_err, unf_err
  );

  modport master (
    output run, br_take, br_target, call_req, call_target, ret_req,
           stack_pc_data,
    input  pc, stack_data, stack_en, stack_pc_en, stack_valid, busy, depth,
           ovf_err, unf_err
  );
endinterface
`default_nettype wire

// File: rtl/pc_stack_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_stack_sequencer
// Description : Program-counter sequencer in front of a hardware return
//               stack. Advances the PC by increment, branch, CALL (push of
//               the return address) or RET (pop through the stack's PC port
//               and reload). Keeps its own depth count so a CALL into a full
//               stack or a RET from an empty one is refused and flagged
//               instead of being issued.
// Ports       : clk   - system clock, rising edge
//               rst_n - synchronous active-low reset
//               bus   - pc_stack_sequencer_if.slave (requests, stack bus,
//                       status)
// Revision    : 1.0 - initial release
// ============================================================================
module pc_stack_sequencer #(
  parameter int                 PC_W        = 16,
  parameter logic [PC_W-1:0]    RESET_VEC   = 16'h0000,
  parameter int                 STACK_DEPTH = 20,
  parameter int                 DEPTH_W     = 5
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  pc_stack_sequencer_if.slave   bus
);

  localparam logic [1:0] RUN       = 2'd0;
  localparam logic [1:0] CALL_PUSH = 2'd1;
  localparam logic [1:0] RET_POP   = 2'd2;
  localparam logic [1:0] RET_LOAD  = 2'd3;

  localparam logic [DEPTH_W-1:0] MAX_DEPTH = DEPTH_W'(STACK_DEPTH);

  logic [1:0]         state;
  logic [PC_W-1:0]    pc_q;
  logic [PC_W-1:0]    stack_data_q;
  logic               stack_en_q;
  logic               stack_pc_en_q;
  logic               stack_valid_q;
  logic [DEPTH_W-1:0] depth_q;
  logic               ovf_q;
  logic               unf_q;
  logic [PC_W-1:0]    pc_inc;

  // Incremented PC doubles as the CALL return address; wraps naturally.
  assign pc_inc = pc_q + PC_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= RUN;
      pc_q          <= RESET_VEC;
      stack_data_q  <= '0;
      stack_en_q    <= 1'b0;
      stack_pc_en_q <= 1'b0;
      stack_valid_q <= 1'b0;
      depth_q       <= '0;
      ovf_q         <= 1'b0;
      unf_q         <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (bus.run) begin
            // Fixed priority; losing requests are simply dropped.
            if (bus.ret_req) begin
              if (depth_q != '0) begin
                stack_en_q    <= 1'b0;
                stack_pc_en_q <= 1'b1;
                stack_valid_q <= 1'b1;
                depth_q       <= depth_q - DEPTH_W'(1);
                state         <= RET_POP;
              end else begin
                unf_q <= 1'b1;
                pc_q  <= pc_inc;
              end
            end else if (bus.call_req) begin
              if (depth_q < MAX_DEPTH) begin
                pc_q          <= bus.call_target;
                stack_data_q  <= pc_inc;
                stack_en_q    <= 1'b1;
                stack_pc_en_q <= 1'b0;
                stack_valid_q <= 1'b1;
                depth_q       <= depth_q + DEPTH_W'(1);
                state         <= CALL_PUSH;
              end else begin
                ovf_q <= 1'b1;
                pc_q  <= pc_inc;
              end
            end else if (bus.br_take) begin
              pc_q <= bus.br_target;
            end else begin
              pc_q <= pc_inc;
            end
          end
        end
        CALL_PUSH: begin
          // Stack captures the push on this edge.
          stack_valid_q <= 1'b0;
          state         <= RUN;
        end
        RET_POP: begin
          // Stack registers its PC output on this edge; data is usable next.
          stack_valid_q <= 1'b0;
          state         <= RET_LOAD;
        end
        RET_LOAD: begin
          pc_q          <= bus.stack_pc_data;
          stack_pc_en_q <= 1'b0;
          state         <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign bus.pc          = pc_q;
  assign bus.stack_data  = stack_data_q;
  assign bus.stack_en    = stack_en_q;
  assign bus.stack_pc_en = stack_pc_en_q;
  assign bus.stack_valid = stack_valid_q;
  assign bus.busy        = (state != RUN);
  assign bus.depth       = depth_q;
  assign bus.ovf_err     = ovf_q;
  assign bus.unf_err     = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_stack_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_stack_sequencer
// Description : Directed self-checking bench for pc_stack_sequencer with
//               hand-computed expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_stack_sequencer;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  pc_stack_sequencer_if #(.PC_W(16), .DEPTH_W(5)) bus ();

  pc_stack_sequencer #(
    .PC_W       (16),
    .RESET_VEC  (16'h0000),
    .STACK_DEPTH(20),
    .DEPTH_W    (5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.run = 1'b0;
    bus.br_take = 1'b0;
    bus.br_target = '0;
    bus.call_req = 1'b0;
    bus.call_target = '0;
    bus.ret_req = 1'b0;
    bus.stack_pc_data = '0;

    // Reset state
    step();
    step();
    check("rst_pc", 32'(bus.pc), 32'h0);
    check("rst_valid", 32'(bus.stack_valid), 32'h0);
    check("rst_depth", 32'(bus.depth), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_errs", {30'h0, bus.ovf_err, bus.unf_err}, 32'h0);

    // Plain increment
    rst_n = 1'b1;
    bus.run = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      check("inc_pc", 32'(bus.pc), 32'(i));
      check("inc_valid", 32'(bus.stack_valid), 32'h0);
    end
    check("inc_depth", 32'(bus.depth), 32'h0);

    // Branch to 0x0010
    bus.br_take = 1'b1;
    bus.br_target = 16'h0010;
    step();
    bus.br_take = 1'b0;
    check("br_pc", 32'(bus.pc), 32'h0010);

    // CALL 0x0200 from 0x0010
    bus.call_req = 1'b1;
    bus.call_target = 16'h0200;
    step();
    bus.call_req = 1'b0;
    check("call_pc", 32'(bus.pc), 32'h0200);
    check("call_data", 32'(bus.stack_data), 32'h0011);
    check("call_en", 32'(bus.stack_en), 32'h1);
    check("call_valid", 32'(bus.stack_valid), 32'h1);
    check("call_depth", 32'(bus.depth), 32'h1);
    check("call_busy", 32'(bus.busy), 32'h1);
    step();
    check("push_valid", 32'(bus.stack_valid), 32'h0);
    check("push_busy", 32'(bus.busy), 32'h0);
    check("push_pc", 32'(bus.pc), 32'h0200);

    // RET, with a branch held during the busy cycles that must be ignored
    bus.ret_req = 1'b1;
    step();
    bus.ret_req = 1'b0;
    check("ret_en", 32'(bus.stack_en), 32'h0);
    check("ret_pcen", 32'(bus.stack_pc_en), 32'h1);
    check("ret_valid", 32'(bus.stack_valid), 32'h1);
    check("ret_pc_hold", 32'(bus.pc), 32'h0200);
    check("ret_depth", 32'(bus.depth), 32'h0);
    bus.br_take = 1'b1;
    bus.br_target = 16'h5555;
    step();
    check("pop_valid", 32'(bus.stack_valid), 32'h0);
    check("pop_pc_hold", 32'(bus.pc), 32'h0200);
    check("pop_busy", 32'(bus.busy), 32'h1);
    bus.stack_pc_data = 16'h0011;
    step();
    bus.br_take = 1'b0;
    check("load_pc", 32'(bus.pc), 32'h0011);
    check("load_pcen", 32'(bus.stack_pc_en), 32'h0);
    check("load_busy", 32'(bus.busy), 32'h0);

    // RET at depth 0 -> underflow, increment
    bus.ret_req = 1'b1;
    step();
    bus.ret_req = 1'b0;
    check("unf_pc", 32'(bus.pc), 32'h0012);
    check("unf_flag", 32'(bus.unf_err), 32'h1);
    check("unf_valid", 32'(bus.stack_valid), 32'h0);
    check("unf_depth", 32'(bus.depth), 32'h0);

    // 20 nested CALLs
    for (int i = 0; i < 20; i++) begin
      bus.call_req = 1'b1;
      bus.call_target = 16'(16'h1000 + i);
      step();
      bus.call_req = 1'b0;
      check("nest_valid", 32'(bus.stack_valid), 32'h1);
      check("nest_depth", 32'(bus.depth), 32'(i + 1));
      if (i == 0) check("nest_data0", 32'(bus.stack_data), 32'h0013);
      step();
    end
    check("nest_pc", 32'(bus.pc), 32'h1013);

    // 21st CALL -> overflow, increment
    bus.call_req = 1'b1;
    bus.call_target = 16'h9999;
    step();
    bus.call_req = 1'b0;
    check("ovf_pc", 32'(bus.pc), 32'h1014);
    check("ovf_flag", 32'(bus.ovf_err), 32'h1);
    check("ovf_valid", 32'(bus.stack_valid), 32'h0);
    check("ovf_depth", 32'(bus.depth), 32'd20);
    check("ovf_busy", 32'(bus.busy), 32'h0);

    // All requests at once -> RET wins
    bus.ret_req = 1'b1;
    bus.call_req = 1'b1;
    bus.br_take = 1'b1;
    bus.call_target = 16'h7777;
    bus.br_target = 16'h6666;
    step();
    bus.ret_req = 1'b0;
    bus.call_req = 1'b0;
    bus.br_take = 1'b0;
    check("pri_valid", 32'(bus.stack_valid), 32'h1);
    check("pri_en", 32'(bus.stack_en), 32'h0);
    check("pri_pcen", 32'(bus.stack_pc_en), 32'h1);
    check("pri_pc", 32'(bus.pc), 32'h1014);
    check("pri_depth", 32'(bus.depth), 32'd19);

    // Reset while in RET_POP
    rst_n = 1'b0;
    step();
    check("rpop_pc", 32'(bus.pc), 32'h0);
    check("rpop_valid", 32'(bus.stack_valid), 32'h0);
    check("rpop_depth", 32'(bus.depth), 32'h0);
    check("rpop_busy", 32'(bus.busy), 32'h0);
    check("rpop_pcen", 32'(bus.stack_pc_en), 32'h0);
    check("rpop_errs", {30'h0, bus.ovf_err, bus.unf_err}, 32'h0);
    rst_n = 1'b1;

    // PC wrap
    bus.br_take = 1'b1;
    bus.br_target = 16'hFFFF;
    step();
    bus.br_take = 1'b0;
    check("wrap_pre", 32'(bus.pc), 32'hFFFF);
    step();
    check("wrap_pc", 32'(bus.pc), 32'h0000);

    // run=0 holds and ignores requests
    bus.run = 1'b0;
    bus.call_req = 1'b1;
    step();
    bus.call_req = 1'b0;
    check("hold_pc", 32'(bus.pc), 32'h0000);
    check("hold_valid", 32'(bus.stack_valid), 32'h0);
    check("hold_depth", 32'(bus.depth), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
